// File: rtl/alu_op_issuer.sv
// ---------------------------------------------------------------------------
// alu_op_issuer
//   Initiator side of the combinational ALU. It accepts one operation request
//   per handshake and drives the ALU inputs from registered copies. It then
//   captures the ALU result and its Zero/Parity/Odd flags and returns them on
//   a response handshake that holds until it is accepted.
//   ADD/LSL/LSR with an amount of 8..15 are chained over two ALU passes. The
//   pass-1 result is fed back as InputA for pass 2.
//
// Ports
//   Clk, Reset_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_op/a/b/imm/amt       opcode, operands, compare immediate, amount 0..15
//   alu_a/b/imm/loop/op      registered drive into the ALU
//   alu_sc_in                ALU shift-carry input, tied low
//   alu_out/zero/parity/odd  combinational result and flags from the ALU
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/zero/parity/odd result and flags of the final pass
//   rsp_passes               number of ALU passes used (1 or 2)
// ---------------------------------------------------------------------------
package Definitions;
    typedef enum logic [3:0] {
        ADD = 4'd0,
        LSL = 4'd1,
        LSR = 4'd2,
        XOR = 4'd3,
        SNE = 4'd4,
        MOV = 4'd5,
        SEQ = 4'd6,
        MSK = 4'd7
    } op_mne;
endpackage

module alu_op_issuer #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [Ops-1:0] req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    input  logic [4:0]     req_imm,
    input  logic [3:0]     req_amt,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [4:0]     alu_imm,
    output logic [2:0]     alu_loop,
    output logic [Ops-1:0] alu_op,
    output logic           alu_sc_in,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_zero,
    input  logic           alu_parity,
    input  logic           alu_odd,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_zero,
    output logic           rsp_parity,
    output logic           rsp_odd,
    output logic [1:0]     rsp_passes
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]   r_alu_a;
    logic [W-1:0]   r_alu_b;
    logic [4:0]     r_alu_imm;
    logic [2:0]     r_alu_loop;
    logic [Ops-1:0] r_alu_op;
    logic           r_chain;
    logic [2:0]     r_loop2;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_zero;
    logic           r_rsp_parity;
    logic           r_rsp_odd;
    logic [1:0]     r_rsp_passes;

    logic           w_accept;
    logic           w_capture;
    logic           w_req_chain;
    logic [2:0]     w_req_loop2;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_capture = ((r_state == PASS1) && !r_chain) || (r_state == PASS2);

    // Only the amount-driven ops chain; for other ops amt[3] is simply dropped.
    assign w_req_chain = req_amt[3] &&
                         ((req_op == Ops'(Definitions::ADD)) ||
                          (req_op == Ops'(Definitions::LSL)) ||
                          (req_op == Ops'(Definitions::LSR)));

    // Second-pass amount is amt-7 (1..7 for amt 8..14). A 3-bit Loop cannot
    // carry 8, so amt=15 is run as 7+7: ADD behaves as amt=14, and a 14-bit
    // shift on an 8-bit datapath already clears the result.
    assign w_req_loop2 = (req_amt == 4'd15) ? 3'd7 : 3'(req_amt - 4'd7);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = PASS1;
            PASS1:   w_next = r_chain ? PASS2 : RESP;
            PASS2:   w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ALU drive registers are loaded at accept so they are already stable
    // during PASS1. They keep their values while idle, so the ALU inputs never
    // glitch between requests.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_imm    <= '0;
            r_alu_loop   <= '0;
            r_alu_op     <= '0;
            r_chain      <= 1'b0;
            r_loop2      <= '0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_parity <= 1'b0;
            r_rsp_odd    <= 1'b0;
            r_rsp_passes <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op   <= req_op;
                r_alu_a    <= req_a;
                r_alu_b    <= req_b;
                r_alu_imm  <= req_imm;
                r_alu_loop <= w_req_chain ? 3'd7 : req_amt[2:0];
                r_chain    <= w_req_chain;
                r_loop2    <= w_req_loop2;
            end
            if ((r_state == PASS1) && r_chain) begin
                r_alu_a    <= alu_out;
                r_alu_loop <= r_loop2;
            end
            if (w_capture) begin
                r_rsp_data   <= alu_out;
                r_rsp_zero   <= alu_zero;
                r_rsp_parity <= alu_parity;
                r_rsp_odd    <= alu_odd;
                r_rsp_passes <= (r_state == PASS2) ? 2'd2 : 2'd1;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_imm    = r_alu_imm;
    assign alu_loop   = r_alu_loop;
    assign alu_op     = r_alu_op;
    assign alu_sc_in  = 1'b0;
    assign rsp_data   = r_rsp_data;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_parity = r_rsp_parity;
    assign rsp_odd    = r_rsp_odd;
    assign rsp_passes = r_rsp_passes;

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;
    import Definitions::*;

    logic       Clk;
    logic       Reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [4:0] req_imm;
    logic [3:0] req_amt;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] alu_imm;
    logic [2:0] alu_loop;
    logic [3:0] alu_op;
    logic       alu_sc_in;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_parity;
    logic       alu_odd;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_parity;
    logic       rsp_odd;
    logic [1:0] rsp_passes;

    int n_chk;
    int n_fail;
    int lat;

    alu_op_issuer #(.W(8), .Ops(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_imm(req_imm), .req_amt(req_amt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_loop(alu_loop),
        .alu_op(alu_op), .alu_sc_in(alu_sc_in),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_odd(alu_odd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_parity(rsp_parity), .rsp_odd(rsp_odd),
        .rsp_passes(rsp_passes)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural stand-in for the combinational ALU.
    always_comb begin
        alu_out = 8'h00;
        case (alu_op)
            ADD:     alu_out = alu_a + 8'(alu_loop);
            LSL:     alu_out = alu_a << alu_loop;
            LSR:     alu_out = alu_a >> alu_loop;
            XOR:     alu_out = alu_a ^ alu_b;
            SNE:     alu_out = (alu_a != {3'b000, alu_imm}) ? 8'h01 : 8'h00;
            MOV:     alu_out = alu_b;
            SEQ:     alu_out = (alu_a == {3'b000, alu_imm}) ? 8'h01 : 8'h00;
            MSK:     alu_out = alu_a & 8'((9'd1 << alu_loop) - 9'd1);
            default: alu_out = 8'h00;
        endcase
    end
    assign alu_zero   = (alu_out == 8'h00);
    assign alu_parity = ^alu_out;
    assign alu_odd    = alu_out[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge and returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [4:0] imm, input logic [3:0] amt);
        @(negedge Clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_imm   = imm;
        req_amt   = amt;
        req_valid = 1'b1;
        @(posedge Clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until rsp_valid:
    // 2 means the response is seen in cycle t+2, 3 means t+3.
    task automatic wait_rsp(input string tag);
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!rsp_valid && lat < 12);
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    // With rsp_ready high, the edge after a response returns to IDLE.
    task automatic drain(input string tag);
        @(negedge Clk);
        chk({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        Reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_imm   = 5'h00;
        req_amt   = 4'd0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_data",   32'(rsp_data),   32'd0);
        chk("rst_rsp_passes", 32'(rsp_passes), 32'd0);
        chk("rst_alu_a",      32'(alu_a),      32'd0);
        chk("rst_alu_loop",   32'(alu_loop),   32'd0);
        chk("rst_alu_sc_in",  32'(alu_sc_in),  32'd0);
        Reset_n = 1'b1;

        // ADD 05 + 3, single pass
        issue(ADD, 8'h05, 8'h00, 5'h00, 4'd3);
        @(negedge Clk);
        chk("add3_p1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("add3_p1_loop",      32'(alu_loop),  32'd3);
        chk("add3_p1_a",         32'(alu_a),     32'h05);
        @(negedge Clk);
        chk("add3_rsp_valid",  32'(rsp_valid),  32'd1);
        chk("add3_data",       32'(rsp_data),   32'h08);
        chk("add3_passes",     32'(rsp_passes), 32'd1);
        chk("add3_zero",       32'(rsp_zero),   32'd0);
        chk("add3_odd",        32'(rsp_odd),    32'd0);
        chk("add3_parity",     32'(rsp_parity), 32'd1);
        chk("add3_req_ready",  32'(req_ready),  32'd0);
        drain("add3");

        // LSL 01 by 10: passes of 7 then 3
        issue(LSL, 8'h01, 8'h00, 5'h00, 4'd10);
        @(negedge Clk);
        chk("lsl10_p1_loop",      32'(alu_loop),  32'd7);
        chk("lsl10_p1_a",         32'(alu_a),     32'h01);
        @(negedge Clk);
        chk("lsl10_p2_loop",      32'(alu_loop),  32'd3);
        chk("lsl10_p2_a",         32'(alu_a),     32'h80);
        chk("lsl10_p2_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge Clk);
        chk("lsl10_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("lsl10_data",      32'(rsp_data),   32'h00);
        chk("lsl10_zero",      32'(rsp_zero),   32'd1);
        chk("lsl10_passes",    32'(rsp_passes), 32'd2);
        drain("lsl10");

        // ADD FE + 12 wraps: FE+7=05, 05+5=0A
        issue(ADD, 8'hFE, 8'h00, 5'h00, 4'd12);
        wait_rsp("add12");
        chk("add12_latency", 32'(lat),        32'd3);
        chk("add12_data",    32'(rsp_data),   32'h0A);
        chk("add12_parity",  32'(rsp_parity), 32'd0);
        chk("add12_passes",  32'(rsp_passes), 32'd2);
        drain("add12");

        // SEQ and SNE with equal operands
        issue(SEQ, 8'h11, 8'h00, 5'h11, 4'd0);
        wait_rsp("seq");
        chk("seq_latency", 32'(lat),      32'd2);
        chk("seq_data",    32'(rsp_data), 32'h01);
        chk("seq_odd",     32'(rsp_odd),  32'd1);
        drain("seq");
        issue(SNE, 8'h11, 8'h00, 5'h11, 4'd0);
        wait_rsp("sne");
        chk("sne_data", 32'(rsp_data), 32'h00);
        chk("sne_zero", 32'(rsp_zero), 32'd1);
        drain("sne");

        // XOR with amt=9: amt[3] ignored, single pass
        issue(XOR, 8'hF0, 8'h3C, 5'h00, 4'd9);
        wait_rsp("xor");
        chk("xor_latency", 32'(lat),        32'd2);
        chk("xor_data",    32'(rsp_data),   32'hCC);
        chk("xor_passes",  32'(rsp_passes), 32'd1);
        chk("xor_loop",    32'(alu_loop),   32'd1);
        drain("xor");

        // amt=15 boundary: LSR 80 clears; ADD behaves as +14
        issue(LSR, 8'h80, 8'h00, 5'h00, 4'd15);
        @(negedge Clk);
        @(negedge Clk);
        chk("lsr15_p2_loop", 32'(alu_loop), 32'd7);
        chk("lsr15_p2_a",    32'(alu_a),    32'h01);
        @(negedge Clk);
        chk("lsr15_data",   32'(rsp_data),   32'h00);
        chk("lsr15_passes", 32'(rsp_passes), 32'd2);
        drain("lsr15");
        issue(ADD, 8'h00, 8'h00, 5'h00, 4'd15);
        wait_rsp("add15");
        chk("add15_data",   32'(rsp_data),   32'h0E);
        chk("add15_parity", 32'(rsp_parity), 32'd1);
        chk("add15_passes", 32'(rsp_passes), 32'd2);
        drain("add15");

        // Backpressure: response held for 5 cycles
        rsp_ready = 1'b0;
        issue(ADD, 8'h10, 8'h00, 5'h00, 4'd2);
        wait_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(rsp_valid),  32'd1);
            chk("bp_hold_data",  32'(rsp_data),   32'h12);
            chk("bp_hold_ready", 32'(req_ready),  32'd0);
            chk("bp_hold_pass",  32'(rsp_passes), 32'd1);
            @(negedge Clk);
        end
        rsp_ready = 1'b1;
        drain("bp");

        // Reset asserted during PASS2 of a chained LSL
        issue(LSL, 8'h01, 8'h00, 5'h00, 4'd9);
        @(negedge Clk);
        @(negedge Clk);
        chk("rstmid_p2_loop", 32'(alu_loop), 32'd2);
        #1 Reset_n = 1'b0;
        #1;
        chk("rstmid_alu_a",     32'(alu_a),     32'd0);
        chk("rstmid_alu_loop",  32'(alu_loop),  32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_rsp_data",  32'(rsp_data),  32'd0);
        repeat (2) @(negedge Clk);
        chk("rstmid_hold_valid", 32'(rsp_valid), 32'd0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rstmid_after_ready", 32'(req_ready), 32'd1);
        chk("rstmid_after_valid", 32'(rsp_valid), 32'd0);

        // Normal operation resumes after reset
        issue(MOV, 8'h00, 8'h5A, 5'h00, 4'd0);
        wait_rsp("mov");
        chk("mov_latency", 32'(lat),        32'd2);
        chk("mov_data",    32'(rsp_data),   32'h5A);
        chk("mov_parity",  32'(rsp_parity), 32'd0);
        drain("mov");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
